// File: rtl/sram_sample_writer_pkg.sv
// Shared types for the capture-side SRAM writer: sample layout, FSM states and
// the per-state SRAM strobe pattern.
package sram_sample_writer_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 16;
   localparam int COUNT_W     = 21;

   typedef struct packed {
      logic [SRAM_DATA_W-1:0] left;
      logic [SRAM_DATA_W-1:0] right;
   } stereo_sample_t;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      SETUP,
      PULSE,
      HOLD,
      DONE_ST
   } wr_state_t;

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic ub_n;
      logic lb_n;
      logic dq_en;
      logic busy;
   } pin_ctl_t;

   // Strobe pattern registered on entry to each state, so the pins never glitch.
   function automatic pin_ctl_t pins_for(input wr_state_t s);
      pin_ctl_t p;
      p = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1,
            dq_en: 1'b0, busy: 1'b0};
      case (s)
         ARMED: p.busy = 1'b1;
         SETUP, PULSE, HOLD: begin
            p.ce_n  = 1'b0;
            p.ub_n  = 1'b0;
            p.lb_n  = 1'b0;
            p.dq_en = 1'b1;
            p.busy  = 1'b1;
            p.we_n  = (s != PULSE);
         end
         default: ;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/sram_sample_writer_fifo.sv
// Synchronous show-ahead FIFO of stereo samples. A push while full is accepted
// only when a pop frees a slot in the same cycle.
module sram_sample_writer_fifo
   import sram_sample_writer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push,
   input  logic           pop,
   input  logic           flush,
   input  stereo_sample_t din,
   output stereo_sample_t dout,
   output logic           full,
   output logic           empty
);

   localparam int             PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = 1;

   stereo_sample_t mem [DEPTH];
   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   logic           do_push;
   logic           do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= din;
   end

endmodule

// File: rtl/sram_sample_writer.sv
// Capture-side SRAM writer: buffers stereo ADC samples and writes each one to
// the async SRAM as a left word followed by a right word.
module sram_sample_writer
   import sram_sample_writer_pkg::*;
#(
   parameter logic [SRAM_ADDR_W-1:0] START_ADDR = 20'h00000,
   parameter logic [SRAM_ADDR_W-1:0] END_ADDR   = 20'hFFFFF,
   parameter logic                   WRAP       = 1'b0,
   parameter int                     WE_CYCLES  = 2,
   parameter int                     FIFO_DEPTH = 4
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   ARM,
   input  logic                   ABORT,
   input  logic                   SAMPLE_VALID,
   input  logic [31:0]            SAMPLE_DATA,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   OVERFLOW,
   output logic [COUNT_W-1:0]     WORDS_WRITTEN
);

   localparam logic [3:0]         WE_LAST   = 4'(WE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = 21'h100000;

   wr_state_t              state;
   pin_ctl_t               pins;
   logic                   right_half;
   logic                   abort_pend;
   logic [3:0]             we_cnt;
   logic [SRAM_DATA_W-1:0] wdata;
   logic [SRAM_DATA_W-1:0] right_hold;

   logic                   capturing;
   logic                   abort_now;
   logic                   end_hit;
   logic                   stop_end;
   logic                   next_right;
   logic                   start_left;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_flush;
   logic                   fifo_full;
   logic                   fifo_empty;
   stereo_sample_t         fifo_dout;

   assign capturing  = (state == ARMED) || (state == SETUP) ||
                       (state == PULSE) || (state == HOLD);
   assign abort_now  = ABORT || abort_pend;
   assign end_hit    = (SRAM_ADDR == END_ADDR);
   assign stop_end   = end_hit && !WRAP;
   assign next_right = (state == HOLD) && !right_half && !stop_end && !abort_now;

   // A new left word starts either from ARMED or straight out of a right-word
   // HOLD, which keeps back-to-back samples at 2*(WE_CYCLES+2) cycles.
   assign start_left = ((state == ARMED) && !ABORT && !fifo_empty) ||
                       ((state == HOLD) && right_half && !stop_end &&
                        !abort_now && !fifo_empty);

   assign fifo_push  = capturing && SAMPLE_VALID;
   assign fifo_pop   = start_left;
   assign fifo_flush = ((state == ARMED) && ABORT) ||
                       ((state == HOLD) && (stop_end || abort_now));

   sram_sample_writer_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RESET_N),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   (SAMPLE_DATA),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= IDLE;
         pins          <= pins_for(IDLE);
         SRAM_ADDR     <= START_ADDR;
         WORDS_WRITTEN <= '0;
         DONE          <= 1'b0;
         OVERFLOW      <= 1'b0;
         right_half    <= 1'b0;
         abort_pend    <= 1'b0;
         we_cnt        <= '0;
      end else begin
         if (fifo_push && fifo_full && !fifo_pop) OVERFLOW <= 1'b1;
         unique case (state)
            IDLE, DONE_ST: begin
               if (ARM && !ABORT) begin
                  state         <= ARMED;
                  pins          <= pins_for(ARMED);
                  SRAM_ADDR     <= START_ADDR;
                  WORDS_WRITTEN <= '0;
                  DONE          <= 1'b0;
                  OVERFLOW      <= 1'b0;
                  abort_pend    <= 1'b0;
               end
            end
            ARMED: begin
               if (ABORT) begin
                  state <= IDLE;
                  pins  <= pins_for(IDLE);
               end else if (!fifo_empty) begin
                  state      <= SETUP;
                  pins       <= pins_for(SETUP);
                  right_half <= 1'b0;
               end
            end
            SETUP: begin
               state  <= PULSE;
               pins   <= pins_for(PULSE);
               we_cnt <= '0;
               if (ABORT) abort_pend <= 1'b1;
            end
            PULSE: begin
               if (ABORT) abort_pend <= 1'b1;
               if (we_cnt == WE_LAST) begin
                  state <= HOLD;
                  pins  <= pins_for(HOLD);
               end else begin
                  we_cnt <= we_cnt + 4'd1;
               end
            end
            HOLD: begin
               SRAM_ADDR  <= end_hit ? START_ADDR : SRAM_ADDR + 20'd1;
               abort_pend <= 1'b0;
               if (WORDS_WRITTEN != COUNT_MAX) WORDS_WRITTEN <= WORDS_WRITTEN + 21'd1;
               if (stop_end) begin
                  state <= DONE_ST;
                  pins  <= pins_for(DONE_ST);
                  DONE  <= 1'b1;
               end else if (abort_now) begin
                  state <= IDLE;
                  pins  <= pins_for(IDLE);
               end else if (!right_half) begin
                  state      <= SETUP;
                  pins       <= pins_for(SETUP);
                  right_half <= 1'b1;
               end else if (!fifo_empty) begin
                  state      <= SETUP;
                  pins       <= pins_for(SETUP);
                  right_half <= 1'b0;
               end else begin
                  state <= ARMED;
                  pins  <= pins_for(ARMED);
               end
            end
            default: begin
               state <= IDLE;
               pins  <= pins_for(IDLE);
            end
         endcase
      end
   end

   // Write data is not reset; it is only visible while dq_en is set.
   always_ff @(posedge CLK) begin
      if (fifo_pop) begin
         wdata      <= fifo_dout.left;
         right_hold <= fifo_dout.right;
      end else if (next_right) begin
         wdata <= right_hold;
      end
   end

   assign SRAM_DQ   = pins.dq_en ? wdata : 16'bz;
   assign SRAM_CE_N = pins.ce_n;
   assign SRAM_OE_N = pins.oe_n;
   assign SRAM_WE_N = pins.we_n;
   assign SRAM_UB_N = pins.ub_n;
   assign SRAM_LB_N = pins.lb_n;
   assign BUSY      = pins.busy;

endmodule

// File: tb/tb_sram_sample_writer.sv
// Bench for sram_sample_writer: a wrapping instance (m_) and a stop-at-end
// instance (d_), each watched by an SRAM write monitor and a word-level model.
module tb_sram_sample_writer;

   localparam logic [19:0] M_START = 20'h00100;
   localparam logic [19:0] M_END   = 20'h00107;
   localparam int          M_WE    = 2;
   localparam int          M_DEPTH = 4;
   localparam logic [19:0] D_START = 20'h00000;
   localparam logic [19:0] D_END   = 20'h00003;
   localparam int          D_WE    = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic        m_arm = 1'b0, m_abort = 1'b0, m_valid = 1'b0;
   logic [31:0] m_data = '0;
   wire  [15:0] m_dq;
   logic [19:0] m_addr;
   logic        m_ce_n, m_oe_n, m_we_n, m_ub_n, m_lb_n, m_busy, m_done, m_ovf;
   logic [20:0] m_count;

   logic        d_arm = 1'b0, d_abort = 1'b0, d_valid = 1'b0;
   logic [31:0] d_data = '0;
   wire  [15:0] d_dq;
   logic [19:0] d_addr;
   logic        d_ce_n, d_oe_n, d_we_n, d_ub_n, d_lb_n, d_busy, d_done, d_ovf;
   logic [20:0] d_count;

   sram_sample_writer #(
      .START_ADDR(M_START), .END_ADDR(M_END), .WRAP(1'b1), .WE_CYCLES(M_WE), .FIFO_DEPTH(M_DEPTH)
   ) u_m (
      .CLK(clk), .RESET_N(rst_n), .ARM(m_arm), .ABORT(m_abort), .SAMPLE_VALID(m_valid),
      .SAMPLE_DATA(m_data), .SRAM_DQ(m_dq), .SRAM_ADDR(m_addr), .SRAM_CE_N(m_ce_n),
      .SRAM_OE_N(m_oe_n), .SRAM_WE_N(m_we_n), .SRAM_UB_N(m_ub_n), .SRAM_LB_N(m_lb_n),
      .BUSY(m_busy), .DONE(m_done), .OVERFLOW(m_ovf), .WORDS_WRITTEN(m_count)
   );

   sram_sample_writer #(
      .START_ADDR(D_START), .END_ADDR(D_END), .WRAP(1'b0), .WE_CYCLES(D_WE), .FIFO_DEPTH(4)
   ) u_d (
      .CLK(clk), .RESET_N(rst_n), .ARM(d_arm), .ABORT(d_abort), .SAMPLE_VALID(d_valid),
      .SAMPLE_DATA(d_data), .SRAM_DQ(d_dq), .SRAM_ADDR(d_addr), .SRAM_CE_N(d_ce_n),
      .SRAM_OE_N(d_oe_n), .SRAM_WE_N(d_we_n), .SRAM_UB_N(d_ub_n), .SRAM_LB_N(d_lb_n),
      .BUSY(d_busy), .DONE(d_done), .OVERFLOW(d_ovf), .WORDS_WRITTEN(d_count)
   );

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SRAM write monitor: one {addr, data} entry per completed WE_N low window.
   logic [35:0] mlog[$];
   logic [35:0] dlog[$];
   logic        prev_we [2];
   int          lo      [2];
   logic [19:0] cap_a   [2];
   logic [15:0] cap_q   [2];

   task automatic mon(input int i, input int width, input logic we_n, input logic ce_n,
                      input logic oe_n, input logic ub_n, input logic lb_n,
                      input logic [19:0] a, input logic [15:0] q);
      if (we_n == 1'b0) begin
         if (prev_we[i]) begin
            cap_a[i] = a;
            cap_q[i] = q;
            lo[i]    = 1;
            chk("strobes_in_pulse", 36'({ce_n, oe_n, ub_n, lb_n}), 36'(4'b0100));
         end else begin
            lo[i]++;
            chk("addr_stable", 36'(a), 36'(cap_a[i]));
            chk("dq_stable", 36'(q), 36'(cap_q[i]));
         end
      end else if (!prev_we[i]) begin
         chk("we_width", 36'(lo[i]), 36'(width));
         chk("hold_addr", 36'(a), 36'(cap_a[i]));
         chk("hold_dq", 36'(q), 36'(cap_q[i]));
         if (i == 0) mlog.push_back({cap_a[i], cap_q[i]});
         else        dlog.push_back({cap_a[i], cap_q[i]});
      end
      prev_we[i] = we_n;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_we[0] = 1'b1;
         prev_we[1] = 1'b1;
      end else begin
         mon(0, M_WE, m_we_n, m_ce_n, m_oe_n, m_ub_n, m_lb_n, m_addr, m_dq);
         mon(1, D_WE, d_we_n, d_ce_n, d_oe_n, d_ub_n, d_lb_n, d_addr, d_dq);
      end
   end

   // Word-level model of the wrapping instance.
   logic [35:0] m_exp[$];
   logic [19:0] m_next = M_START;
   int          m_cnt  = 0;

   function automatic logic [19:0] adv(input logic [19:0] a);
      return (a == M_END) ? M_START : a + 20'd1;
   endfunction

   task automatic m_word(input logic [15:0] w);
      m_exp.push_back({m_next, w});
      m_next = adv(m_next);
      m_cnt++;
   endtask

   task automatic m_restart();
      m_next = M_START;
      m_cnt  = 0;
      m_exp.delete();
      mlog.delete();
   endtask

   task automatic m_compare(input string tag);
      chk({tag, "_nwords"}, 36'(mlog.size()), 36'(m_exp.size()));
      while (m_exp.size() > 0 && mlog.size() > 0) chk(tag, mlog.pop_front(), m_exp.pop_front());
      mlog.delete();
      m_exp.delete();
      chk({tag, "_count"}, 36'(m_count), 36'(m_cnt));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Consecutive-cycle burst into an idle writer: DEPTH+1 samples fit, the rest drop.
   task automatic m_burst(input int k);
      logic [31:0] s;
      for (int j = 0; j < k; j++) begin
         s       = $urandom;
         m_data  = s;
         m_valid = 1'b1;
         if (j < M_DEPTH + 1) begin
            m_word(s[31:16]);
            m_word(s[15:0]);
         end
         step(1);
      end
      m_valid = 1'b0;
   endtask

   task automatic d_check(input string tag, input logic [31:0] s0, input logic [31:0] s1);
      logic [35:0] e [4];
      e[0] = {D_START,          s0[31:16]};
      e[1] = {D_START + 20'd1,  s0[15:0]};
      e[2] = {D_START + 20'd2,  s1[31:16]};
      e[3] = {D_START + 20'd3,  s1[15:0]};
      chk({tag, "_nwords"}, 36'(dlog.size()), 36'd4);
      for (int j = 0; j < 4 && dlog.size() > 0; j++) chk(tag, dlog.pop_front(), e[j]);
      dlog.delete();
      chk({tag, "_done"}, 36'(d_done), 36'd1);
      chk({tag, "_busy"}, 36'(d_busy), 36'd0);
      chk({tag, "_ovf"}, 36'(d_ovf), 36'd0);
      chk({tag, "_count"}, 36'(d_count), 36'd4);
   endtask

   logic [31:0] ds [3];
   logic        exp_ovf;
   int          k;

   initial begin
      // Reset values
      step(2);
      @(negedge clk);
      chk("rst_strobes", 36'({m_ce_n, m_oe_n, m_we_n, m_ub_n, m_lb_n}), 36'(5'b11111));
      chk("rst_addr", 36'(m_addr), 36'(M_START));
      chk("rst_flags", 36'({m_busy, m_done, m_ovf}), 36'd0);
      chk("rst_count", 36'(m_count), 36'd0);
      chk("rst_dq_en", 36'(u_m.pins.dq_en), 36'd0);
      rst_n = 1'b1;

      // 1: single sample, latency and word split
      step(1);
      m_arm = 1'b1;
      step(1);
      m_arm = 1'b0;
      @(negedge clk);
      chk("t1_busy_armed", 36'(m_busy), 36'd1);
      m_restart();
      step(1);
      m_data  = 32'hABCD1234;
      m_valid = 1'b1;
      m_word(16'hABCD);
      m_word(16'h1234);
      step(1);
      m_valid = 1'b0;
      step(1);
      @(negedge clk);
      chk("t1_setup_lat", 36'({m_ce_n, m_we_n}), 36'(2'b01));
      @(negedge clk);
      chk("t1_pulse_lat", 36'(m_we_n), 36'd0);
      chk("t1_pulse_dq", 36'(m_dq), 36'h0ABCD);
      step(10);
      @(negedge clk);
      m_compare("t1");
      chk("t1_busy", 36'(m_busy), 36'd1);
      chk("t1_addr", 36'(m_addr), 36'(M_START + 20'd2));

      // 2: six back-to-back samples, sixth dropped; addresses wrap past M_END
      step(1);
      m_burst(6);
      step(60);
      @(negedge clk);
      m_compare("t2");
      chk("t2_ovf", 36'(m_ovf), 36'd1);

      // 3: stop at END_ADDR, spaced samples then a burst flushed by DONE
      step(1);
      d_arm = 1'b1;
      step(1);
      d_arm = 1'b0;
      for (int j = 0; j < 3; j++) begin
         ds[j]   = $urandom;
         d_data  = ds[j];
         d_valid = 1'b1;
         step(1);
         d_valid = 1'b0;
         step(13);
      end
      @(negedge clk);
      d_check("t3_spaced", ds[0], ds[1]);
      step(1);
      d_arm = 1'b1;
      step(1);
      d_arm = 1'b0;
      for (int j = 0; j < 3; j++) begin
         ds[j]   = $urandom;
         d_data  = ds[j];
         d_valid = 1'b1;
         step(1);
      end
      d_valid = 1'b0;
      step(30);
      @(negedge clk);
      d_check("t3_burst", ds[0], ds[1]);
      step(1);
      d_arm = 1'b1;
      step(1);
      d_arm = 1'b0;
      @(negedge clk);
      chk("t3_rearm", 36'({d_busy, d_done, d_addr, d_count}), 36'({1'b1, 1'b0, D_START, 21'd0}));

      // 4: ABORT during the left word's pulse
      step(1);
      m_data  = $urandom;
      m_valid = 1'b1;
      m_word(m_data[31:16]);
      step(1);
      m_valid = 1'b0;
      step(2);
      m_abort = 1'b1;
      step(1);
      m_abort = 1'b0;
      step(12);
      @(negedge clk);
      m_compare("t4");
      chk("t4_idle", 36'({m_busy, m_ce_n}), 36'(2'b01));
      step(1);
      m_arm = 1'b1;
      step(1);
      m_arm = 1'b0;
      @(negedge clk);
      chk("t4_rearm", 36'({m_busy, m_addr, m_count}), 36'({1'b1, M_START, 21'd0}));
      m_restart();

      // 5: reset in the middle of a pulse
      step(1);
      m_data  = $urandom;
      m_valid = 1'b1;
      step(1);
      m_valid = 1'b0;
      step(2);
      chk("t5_in_pulse", 36'(m_we_n), 36'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_we", 36'(m_we_n), 36'd1);
      chk("t5_rst_dq_en", 36'(u_m.pins.dq_en), 36'd0);
      chk("t5_rst_outs", 36'({m_ce_n, m_busy, m_ovf, m_addr}), 36'({1'b1, 1'b0, 1'b0, M_START}));
      step(2);
      rst_n = 1'b1;
      m_restart();
      m_arm = 1'b1;
      step(1);
      m_arm = 1'b0;
      m_data  = $urandom;
      m_valid = 1'b1;
      m_word(m_data[31:16]);
      m_word(m_data[15:0]);
      step(1);
      m_valid = 1'b0;
      step(12);
      @(negedge clk);
      m_compare("t5");

      // 6: ARM+ABORT from IDLE, then SAMPLE_VALID while IDLE
      step(1);
      m_abort = 1'b1;
      step(1);
      m_abort = 1'b0;
      m_arm   = 1'b1;
      m_abort = 1'b1;
      step(1);
      m_arm   = 1'b0;
      m_abort = 1'b0;
      @(negedge clk);
      chk("t6_arm_abort", 36'(m_busy), 36'd0);
      step(1);
      m_data  = $urandom;
      m_valid = 1'b1;
      step(1);
      m_valid = 1'b0;
      step(12);
      @(negedge clk);
      m_compare("t6");
      chk("t6_quiet", 36'({m_busy, m_ovf, m_ce_n}), 36'(3'b001));

      // Randomised bursts through the wrapping instance
      step(1);
      m_arm = 1'b1;
      step(1);
      m_arm = 1'b0;
      m_restart();
      exp_ovf = 1'b0;
      for (int it = 0; it < 12; it++) begin
         k = $urandom_range(1, 6);
         if (k > M_DEPTH + 1) exp_ovf = 1'b1;
         m_burst(k);
         step(8 * k + 10 + $urandom_range(0, 5));
         @(negedge clk);
         m_compare("rand");
         chk("rand_ovf", 36'(m_ovf), 36'(exp_ovf));
         step(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
